riscv_fetch_unit: RTL
=====================

// Module: riscv_fetch_unit
// PURPOSE
//  Multicycle instruction fetch stage; sits directly upstream of controller_v1 and feeds its opcode/funct7.
//  Owns the PC, issues one instruction-memory read per fetch_start, latches the instruction register (IR).
//  Presents IR fields to the controller with a valid/ready handshake; accepts PC redirects (branch/jump/trap).
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  NOP_INSTR 32'h0000_0013 IR reset value (addi x0,x0,0)
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     reset, asynchronous, active-high
//  fetch_start    in   1     controller in FETCH state; request next instruction
//  redirect_valid in   1     load redirect_pc as next fetch address
//  redirect_pc    in   XLEN  redirect target
//  imem_req       out  1     memory read request
//  imem_addr      out  XLEN  read address (= pc)
//  imem_gnt       in   1     request accepted (same cycle as req)
//  imem_rvalid    in   1     read data valid
//  imem_rdata     in   XLEN  read data
//  instr_valid    out  1     IR holds a valid instruction
//  instr_ready    in   1     controller consumed IR
//  instr          out  XLEN  IR
//  opcode         out  7     IR[6:0]
//  funct7         out  7     IR[31:25]
//  pc             out  XLEN  address of instruction in IR / being fetched
//  busy           out  1     state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, IR=NOP_INSTR, imem_req=0, instr_valid=0, kill=0.
//  FSM states: IDLE, REQ, WAIT, HOLD. Moore outputs: imem_req=1 only in REQ; instr_valid=1 only in HOLD.
//  IDLE: fetch_start -> REQ. Else stay.
//  REQ: imem_addr=pc held stable until imem_gnt; gnt -> WAIT. Request never withdrawn before gnt.
//  WAIT: imem_rvalid -> IR<=imem_rdata, HOLD (or REQ if kill; IR untouched, kill cleared).
//  HOLD: instr_ready -> pc<=pc+4 (mod 2^XLEN, wraps), IDLE. Else hold IR/pc stable.
//  Min latency fetch_start -> instr_valid: 3 cycles with gnt in REQ cycle and rvalid first WAIT cycle.
//  imem_rvalid outside WAIT ignored (covers stale response after reset).
//  Redirect: IDLE -> pc<=redirect_pc; fetch_start same cycle still -> REQ (uses new pc).
//   REQ/WAIT -> target stored in pc_redir, kill=1; REQ keeps old addr until gnt; in-flight response discarded, then pc<=pc_redir, re-REQ.
//   HOLD -> instr_valid drops next cycle, pc<=redirect_pc, IDLE; redirect beats concurrent instr_ready (no pc+4).
//   Repeated redirect while kill=1: latest target wins.
//  redirect_pc[1:0] ignored (forced 00) unless FETCH_FAULT_EN.
// CONFIGURATION
//  Macro FETCH_FAULT_EN:
//   Defined: adds in imem_err (1, with rvalid) and out fetch_fault (1). Misaligned pc[1:0]!=0 in REQ: no
//    request, fetch_fault=1, go HOLD with IR=NOP_INSTR. imem_err with rvalid: same. fetch_fault clears on leaving HOLD.
//   Undefined: ports absent, pc[1:0] tied 00, no fault path.
// TESTING
//  Reset then fetch_start, gnt immediate, rvalid next, rdata=32'h0020_8033 -> instr_valid cycle 3, opcode=7'h33, funct7=0, pc=0.
//  instr_ready in HOLD -> pc=4, IDLE; gnt delayed 3 cycles -> imem_req/addr stable all 4 cycles.
//  redirect_pc=32'h100 during WAIT -> response discarded, imem_addr=32'h100 next REQ, instr_valid never for old data.
//  pc=32'hFFFF_FFFC, consume -> pc wraps to 0; redirect+instr_ready in HOLD -> pc=redirect_pc.
//  rst asserted in WAIT, rvalid arrives after -> ignored, pc=RESET_PC, IR=32'h13, instr_valid=0.
//  FETCH_FAULT_EN: redirect_pc=32'h102 then fetch -> imem_req never 1, fetch_fault=1, instr=32'h13.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Multicycle instruction fetch stage: owns the PC, fetches one instruction per fetch_start
// into the IR and hands it to the controller. Optional fault path enabled by `FETCH_FAULT_EN.
module riscv_fetch_unit #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_start,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic            busy
`ifdef FETCH_FAULT_EN
    ,
    input  logic            imem_err,
    output logic            fetch_fault
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

`ifdef FETCH_FAULT_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}};
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_redir_r;
    logic [XLEN-1:0] ir_r;
    logic            kill_r;
    logic            imem_req_r;
    logic            instr_valid_r;
    logic            busy_r;
`ifdef FETCH_FAULT_EN
    logic            fetch_fault_r;
`endif

    logic [XLEN-1:0] redir_s;
    logic [XLEN-1:0] idle_target_s;
    logic [XLEN-1:0] retarget_s;

    assign redir_s       = redirect_pc & ALIGN_MASK;
    assign idle_target_s = redirect_valid ? redir_s : pc_r;
    // A redirect arriving together with the killed response is newer than any stored target.
    assign retarget_s    = redirect_valid ? redir_s : pc_redir_r;

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_r;
    assign instr       = ir_r;
    assign opcode      = ir_r[6:0];
    assign funct7      = ir_r[31:25];
    assign pc          = pc_r;
    assign busy        = busy_r;
`ifdef FETCH_FAULT_EN
    assign fetch_fault = fetch_fault_r;
`endif

    // Fetch FSM with all handshake outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC & ALIGN_MASK;
            pc_redir_r    <= RESET_PC & ALIGN_MASK;
            ir_r          <= NOP_INSTR;
            kill_r        <= 1'b0;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef FETCH_FAULT_EN
            fetch_fault_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_r <= redir_s;
                    end
                    if (fetch_start) begin
                        state_r    <= ST_REQ;
                        busy_r     <= 1'b1;
                        imem_req_r <= word_aligned(idle_target_s[1:0]);
                    end
                end
                ST_REQ: begin
`ifdef FETCH_FAULT_EN
                    if (!word_aligned(pc_r[1:0])) begin
                        state_r       <= ST_HOLD;
                        ir_r          <= NOP_INSTR;
                        fetch_fault_r <= 1'b1;
                        instr_valid_r <= 1'b1;
                        imem_req_r    <= 1'b0;
                        kill_r        <= 1'b0;
                    end else
`endif
                    begin
                        // Address stays on the bus until granted; a redirect only arms the kill.
                        if (redirect_valid) begin
                            pc_redir_r <= redir_s;
                            kill_r     <= 1'b1;
                        end
                        if (imem_gnt) begin
                            state_r    <= ST_WAIT;
                            imem_req_r <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_r || redirect_valid) begin
                            kill_r     <= 1'b0;
                            pc_r       <= retarget_s;
                            state_r    <= ST_REQ;
                            imem_req_r <= word_aligned(retarget_s[1:0]);
                        end else begin
`ifdef FETCH_FAULT_EN
                            if (imem_err) begin
                                ir_r          <= NOP_INSTR;
                                fetch_fault_r <= 1'b1;
                            end else begin
                                ir_r <= imem_rdata;
                            end
`else
                            ir_r <= imem_rdata;
`endif
                            state_r       <= ST_HOLD;
                            instr_valid_r <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        pc_redir_r <= redir_s;
                        kill_r     <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Redirect has priority over consumption: no pc+4 when both arrive.
                    if (redirect_valid) begin
                        pc_r          <= redir_s;
                        state_r       <= ST_IDLE;
                        instr_valid_r <= 1'b0;
                        busy_r        <= 1'b0;
`ifdef FETCH_FAULT_EN
                        fetch_fault_r <= 1'b0;
`endif
                    end else if (instr_ready) begin
                        pc_r          <= pc_r + PC_STEP;
                        state_r       <= ST_IDLE;
                        instr_valid_r <= 1'b0;
                        busy_r        <= 1'b0;
`ifdef FETCH_FAULT_EN
                        fetch_fault_r <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    kill_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule
